// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the multi-phase intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_ALLRED = 3'd3,
        S_WALK   = 3'd4,
        S_CLEAR  = 3'd5,
        S_FLASH  = 3'd6
    } state_t;

    // Vehicle head encoding {red, yellow, green}
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    // Pedestrian head encoding {red, walk}
    localparam logic [1:0] PED_DONT = 2'b10;
    localparam logic [1:0] PED_WALK = 2'b01;
    localparam logic [1:0] PED_OFF  = 2'b00;

    // Seconds counter width: every interval is 1..99 s
    localparam int SEC_W = 7;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Request/light bundle between the intersection controller and the board.
interface traffic_phase_ctrl_if #(
    parameter int N_PHASES = 4
) ();
    localparam int PHASE_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;

    logic [N_PHASES-1:0]   ped_req;
    logic                  flash_mode;
    logic [3*N_PHASES-1:0] veh_lights;
    logic [2*N_PHASES-1:0] ped_lights;
    logic [N_PHASES-1:0]   ped_pending;
    logic [PHASE_W-1:0]    phase_idx;
    logic                  tick;
    logic [3:0]            bcd_ones;
    logic [3:0]            bcd_tens;

    // Board / stimulus side
    modport master (
        output ped_req, flash_mode,
        input  veh_lights, ped_lights, ped_pending, phase_idx, tick, bcd_ones, bcd_tens
    );

    // Controller side
    modport slave (
        input  ped_req, flash_mode,
        output veh_lights, ped_lights, ped_pending, phase_idx, tick, bcd_ones, bcd_tens
    );
endinterface

// File: rtl/sec_tick_gen.sv
// Divides clk down to a one-cycle pulse per second; divider runs 0..CLK_FREQ-1.
module sec_tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_FREQ - 1);

    logic [DIV_W-1:0] divider;

    // Free-running divider, wraps at the last cycle of each second
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider <= '0;
        end else if (divider == DIV_MAX) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    assign tick = (divider == DIV_MAX);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-phase intersection controller with shared pedestrian interval,
// flash mode and a two-digit BCD countdown.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_RESET  | post-reset all-red hold
// S_GREEN  | phase phase_idx green
// S_YELLOW | phase phase_idx yellow
// S_ALLRED | clearance; picks flash / walk / next green at its end
// S_WALK   | served phases show pedestrian walk, all vehicles red
// S_CLEAR  | pedestrian clearance, everything red
// S_FLASH  | night/fault blinking, left on a tick with flash_mode low
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int N_PHASES = 4,
    parameter int T_GREEN  = 18,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 5,
    parameter int T_CLEAR  = 3,
    parameter int T_RESET  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_phase_ctrl_if.slave   bus
);
    // Must agree with the N_PHASES the connected interface was built with
    localparam int PHASE_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(N_PHASES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [SEC_W-1:0]     sec_left;
    logic [PHASE_W-1:0]   phase_idx;
    logic [N_PHASES-1:0]  ped_pending;
    logic [N_PHASES-1:0]  served_mask;
    logic                 blink_off;
    logic                 tick;
    logic                 entering;
    logic [3*N_PHASES-1:0] veh_lights;
    logic [2*N_PHASES-1:0] ped_lights;
    logic [SEC_W-1:0]     disp_val;

    // Reload value for the seconds counter on entry to a state
    function automatic logic [SEC_W-1:0] load_val(input state_t s);
        case (s)
            S_GREEN:  return SEC_W'(T_GREEN - 1);
            S_YELLOW: return SEC_W'(T_YELLOW - 1);
            S_ALLRED: return SEC_W'(T_ALLRED - 1);
            S_WALK:   return SEC_W'(T_WALK - 1);
            S_CLEAR:  return SEC_W'(T_CLEAR - 1);
            S_FLASH:  return '0;
            default:  return SEC_W'(T_RESET - 1);
        endcase
    endfunction

    sec_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: only on a tick, and only when the interval has expired
    // (flash leaves on any tick once flash_mode drops)
    always_comb begin
        state_nxt = state;
        if (tick) begin
            if (state == S_FLASH) begin
                if (!bus.flash_mode) begin
                    state_nxt = S_ALLRED;
                end
            end else if (sec_left == '0) begin
                case (state)
                    S_RESET:  state_nxt = S_GREEN;
                    S_GREEN:  state_nxt = S_YELLOW;
                    S_YELLOW: state_nxt = S_ALLRED;
                    S_ALLRED: begin
                        if (bus.flash_mode) begin
                            state_nxt = S_FLASH;
                        end else if (|ped_pending) begin
                            state_nxt = S_WALK;
                        end else begin
                            state_nxt = S_GREEN;
                        end
                    end
                    S_WALK:   state_nxt = S_CLEAR;
                    S_CLEAR:  state_nxt = S_GREEN;
                    default:  state_nxt = S_RESET;
                endcase
            end
        end
    end

    assign entering = (state_nxt != state);

    // Countdown, phase pointer, pedestrian latches and flash blink phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_left    <= SEC_W'(T_RESET - 1);
            phase_idx   <= '0;
            ped_pending <= '0;
            served_mask <= '0;
            blink_off   <= 1'b0;
        end else begin
            if (entering) begin
                sec_left <= load_val(state_nxt);
            end else if (tick && state != S_FLASH) begin
                sec_left <= sec_left - 1'b1;
            end

            if (entering && state_nxt == S_GREEN) begin
                if (state == S_RESET || phase_idx == LAST_PHASE) begin
                    phase_idx <= '0;
                end else begin
                    phase_idx <= phase_idx + 1'b1;
                end
            end else if (entering && state == S_FLASH) begin
                // Park on the last phase so the round-robin resumes at phase 0
                phase_idx <= LAST_PHASE;
            end

            if (state == S_RESET || state == S_FLASH || state_nxt == S_FLASH) begin
                ped_pending <= '0;
            end else if (entering && state_nxt == S_WALK) begin
                ped_pending <= '0;
            end else begin
                ped_pending <= ped_pending | bus.ped_req;
            end

            // A request arriving on the walk entry edge joins this walk
            if (entering && state_nxt == S_WALK) begin
                served_mask <= ped_pending | bus.ped_req;
            end

            if (entering && state_nxt == S_FLASH) begin
                blink_off <= 1'b0;
            end else if (state == S_FLASH && tick) begin
                blink_off <= ~blink_off;
            end
        end
    end

    // Lights and display decoded from registered state
    always_comb begin
        veh_lights = '0;
        ped_lights = '0;
        for (int p = 0; p < N_PHASES; p++) begin
            veh_lights[3*p +: 3] = LT_RED;
            ped_lights[2*p +: 2] = PED_DONT;
            case (state)
                S_GREEN: begin
                    if (phase_idx == PHASE_W'(p)) veh_lights[3*p +: 3] = LT_GRN;
                end
                S_YELLOW: begin
                    if (phase_idx == PHASE_W'(p)) veh_lights[3*p +: 3] = LT_YEL;
                end
                S_WALK: begin
                    if (served_mask[p]) ped_lights[2*p +: 2] = PED_WALK;
                end
                S_FLASH: begin
                    if (blink_off) begin
                        veh_lights[3*p +: 3] = LT_OFF;
                    end else if (p == 0) begin
                        veh_lights[3*p +: 3] = LT_YEL;
                    end else begin
                        veh_lights[3*p +: 3] = LT_RED;
                    end
                    ped_lights[2*p +: 2] = PED_OFF;
                end
                default: ;
            endcase
        end
        disp_val = (state == S_FLASH) ? '0 : sec_left + 1'b1;
    end

    assign bus.veh_lights  = veh_lights;
    assign bus.ped_lights  = ped_lights;
    assign bus.ped_pending = ped_pending;
    assign bus.phase_idx   = phase_idx;
    assign bus.tick        = tick;
    assign bus.bcd_tens    = 4'(disp_val / 7'd10);
    assign bus.bcd_ones    = 4'(disp_val % 7'd10);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with an 8-cycle second, 3 phases.
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    traffic_phase_ctrl_if #(.N_PHASES(3)) bus ();

    traffic_phase_ctrl #(
        .CLK_FREQ (8),
        .N_PHASES (3),
        .T_GREEN  (4),
        .T_YELLOW (2),
        .T_ALLRED (1),
        .T_WALK   (3),
        .T_CLEAR  (2),
        .T_RESET  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // cyc = number of rising edges since reset release; we sit on the falling edge
    task automatic goto(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pulse_req(input logic [2:0] r);
        bus.ped_req = r;
        goto(cyc + 1);
        bus.ped_req = 3'b000;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.ped_req = 3'b000;
        bus.flash_mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.veh_lights !== 9'b100100100) begin fails++; $display("FAIL reset_veh: got %b want %b", bus.veh_lights, 9'b100100100); end
        checks++; if (bus.ped_lights !== 6'b101010) begin fails++; $display("FAIL reset_ped: got %b want %b", bus.ped_lights, 6'b101010); end
        checks++; if (bus.ped_pending !== 3'b000) begin fails++; $display("FAIL reset_pending: got %b want 000", bus.ped_pending); end
        checks++; if (bus.phase_idx !== 2'd0) begin fails++; $display("FAIL reset_phase: got %0d want 0", bus.phase_idx); end
        checks++; if (bus.tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
        checks++; if ({bus.bcd_tens, bus.bcd_ones} !== 8'h03) begin fails++; $display("FAIL reset_bcd: got %h want 03", {bus.bcd_tens, bus.bcd_ones}); end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_normal_cycle;
        goto(8);
        checks++; if ({bus.bcd_tens, bus.bcd_ones} !== 8'h02) begin fails++; $display("FAIL rst_bcd2: got %h want 02", {bus.bcd_tens, bus.bcd_ones}); end
        goto(16);
        checks++; if ({bus.bcd_tens, bus.bcd_ones} !== 8'h01) begin fails++; $display("FAIL rst_bcd1: got %h want 01", {bus.bcd_tens, bus.bcd_ones}); end
        goto(23);
        checks++; if (bus.tick !== 1'b1 || bus.veh_lights !== 9'b100100100) begin fails++; $display("FAIL rst_last: tick %b veh %b want 1 100100100", bus.tick, bus.veh_lights); end
        goto(24);
        checks++; if (bus.veh_lights !== 9'b100100001) begin fails++; $display("FAIL p0_green: got %b want %b", bus.veh_lights, 9'b100100001); end
        checks++; if ({bus.bcd_tens, bus.bcd_ones} !== 8'h04) begin fails++; $display("FAIL green_bcd: got %h want 04", {bus.bcd_tens, bus.bcd_ones}); end
        goto(55);
        checks++; if (bus.veh_lights !== 9'b100100001) begin fails++; $display("FAIL p0_green_end: got %b want %b", bus.veh_lights, 9'b100100001); end
        goto(56);
        checks++; if (bus.veh_lights !== 9'b100100010 || {bus.bcd_tens, bus.bcd_ones} !== 8'h02) begin fails++; $display("FAIL p0_yellow: veh %b bcd %h want 100100010 02", bus.veh_lights, {bus.bcd_tens, bus.bcd_ones}); end
        goto(72);
        checks++; if (bus.veh_lights !== 9'b100100100 || {bus.bcd_tens, bus.bcd_ones} !== 8'h01) begin fails++; $display("FAIL allred: veh %b bcd %h want 100100100 01", bus.veh_lights, {bus.bcd_tens, bus.bcd_ones}); end
        goto(80);
        checks++; if (bus.veh_lights !== 9'b100001100 || bus.phase_idx !== 2'd1) begin fails++; $display("FAIL p1_green: veh %b idx %0d want 100001100 1", bus.veh_lights, bus.phase_idx); end
        goto(136);
        checks++; if (bus.veh_lights !== 9'b001100100 || bus.phase_idx !== 2'd2) begin fails++; $display("FAIL p2_green: veh %b idx %0d want 001100100 2", bus.veh_lights, bus.phase_idx); end
        goto(192);
        checks++; if (bus.veh_lights !== 9'b100100001 || bus.phase_idx !== 2'd0) begin fails++; $display("FAIL wrap_p0: veh %b idx %0d want 100100001 0", bus.veh_lights, bus.phase_idx); end
    endtask

    task automatic test_ped_walk;
        pulse_req(3'b100);
        checks++; if (bus.ped_pending !== 3'b100) begin fails++; $display("FAIL ped_latch: got %b want 100", bus.ped_pending); end
        goto(247);
        checks++; if (bus.ped_pending !== 3'b100 || bus.ped_lights !== 6'b101010) begin fails++; $display("FAIL ped_wait: pend %b ped %b want 100 101010", bus.ped_pending, bus.ped_lights); end
        goto(248);
        checks++; if (bus.ped_lights !== 6'b011010 || bus.ped_pending !== 3'b000) begin fails++; $display("FAIL walk_p2: ped %b pend %b want 011010 000", bus.ped_lights, bus.ped_pending); end
        checks++; if (bus.veh_lights !== 9'b100100100 || {bus.bcd_tens, bus.bcd_ones} !== 8'h03) begin fails++; $display("FAIL walk_veh: veh %b bcd %h want 100100100 03", bus.veh_lights, {bus.bcd_tens, bus.bcd_ones}); end
        goto(271);
        checks++; if (bus.ped_lights !== 6'b011010) begin fails++; $display("FAIL walk_end: got %b want 011010", bus.ped_lights); end
        goto(272);
        checks++; if (bus.ped_lights !== 6'b101010 || {bus.bcd_tens, bus.bcd_ones} !== 8'h02) begin fails++; $display("FAIL clear: ped %b bcd %h want 101010 02", bus.ped_lights, {bus.bcd_tens, bus.bcd_ones}); end
        goto(288);
        checks++; if (bus.veh_lights !== 9'b100001100 || bus.phase_idx !== 2'd1 || bus.ped_pending !== 3'b000) begin fails++; $display("FAIL after_clear: veh %b idx %0d pend %b want 100001100 1 000", bus.veh_lights, bus.phase_idx, bus.ped_pending); end
    endtask

    task automatic test_ped_during_walk;
        goto(290);
        pulse_req(3'b100);
        goto(344);
        checks++; if (bus.ped_lights !== 6'b011010) begin fails++; $display("FAIL walk2_p2: got %b want 011010", bus.ped_lights); end
        goto(350);
        pulse_req(3'b001);
        checks++; if (bus.ped_pending !== 3'b001 || bus.ped_lights !== 6'b011010) begin fails++; $display("FAIL req_in_walk: pend %b ped %b want 001 011010", bus.ped_pending, bus.ped_lights); end
        goto(384);
        checks++; if (bus.veh_lights !== 9'b001100100 || bus.ped_pending !== 3'b001) begin fails++; $display("FAIL p2_after_walk: veh %b pend %b want 001100100 001", bus.veh_lights, bus.ped_pending); end
        goto(440);
        checks++; if (bus.ped_lights !== 6'b101001 || bus.ped_pending !== 3'b000) begin fails++; $display("FAIL walk_p0: ped %b pend %b want 101001 000", bus.ped_lights, bus.ped_pending); end
        goto(480);
        checks++; if (bus.veh_lights !== 9'b100100001 || bus.phase_idx !== 2'd0) begin fails++; $display("FAIL clear_wrap: veh %b idx %0d want 100100001 0", bus.veh_lights, bus.phase_idx); end
    endtask

    task automatic test_simultaneous;
        goto(482);
        pulse_req(3'b010);
        goto(535);
        pulse_req(3'b111);
        checks++; if (bus.ped_lights !== 6'b010101 || bus.ped_pending !== 3'b000) begin fails++; $display("FAIL walk_all: ped %b pend %b want 010101 000", bus.ped_lights, bus.ped_pending); end
        goto(576);
        checks++; if (bus.veh_lights !== 9'b100001100 || bus.ped_pending !== 3'b000) begin fails++; $display("FAIL after_all: veh %b pend %b want 100001100 000", bus.veh_lights, bus.ped_pending); end
    endtask

    task automatic test_flash;
        goto(586);
        bus.flash_mode = 1'b1;
        goto(608);
        checks++; if (bus.veh_lights !== 9'b100010100) begin fails++; $display("FAIL flash_yellow_first: got %b want 100010100", bus.veh_lights); end
        goto(631);
        checks++; if (bus.veh_lights !== 9'b100100100) begin fails++; $display("FAIL flash_allred_first: got %b want 100100100", bus.veh_lights); end
        goto(632);
        checks++; if (bus.veh_lights !== 9'b100100010 || bus.ped_lights !== 6'b000000) begin fails++; $display("FAIL flash_on: veh %b ped %b want 100100010 000000", bus.veh_lights, bus.ped_lights); end
        checks++; if ({bus.bcd_tens, bus.bcd_ones} !== 8'h00) begin fails++; $display("FAIL flash_bcd: got %h want 00", {bus.bcd_tens, bus.bcd_ones}); end
        goto(639);
        checks++; if (bus.veh_lights !== 9'b100100010) begin fails++; $display("FAIL flash_on_hold: got %b want 100100010", bus.veh_lights); end
        goto(640);
        checks++; if (bus.veh_lights !== 9'b000000000) begin fails++; $display("FAIL flash_off: got %b want 000000000", bus.veh_lights); end
        goto(642);
        pulse_req(3'b001);
        checks++; if (bus.ped_pending !== 3'b000) begin fails++; $display("FAIL flash_ignore_req: got %b want 000", bus.ped_pending); end
        goto(648);
        checks++; if (bus.veh_lights !== 9'b100100010) begin fails++; $display("FAIL flash_on2: got %b want 100100010", bus.veh_lights); end
        goto(650);
        bus.flash_mode = 1'b0;
        goto(656);
        checks++; if (bus.veh_lights !== 9'b100100100 || bus.phase_idx !== 2'd2 || {bus.bcd_tens, bus.bcd_ones} !== 8'h01) begin fails++; $display("FAIL flash_exit: veh %b idx %0d bcd %h want 100100100 2 01", bus.veh_lights, bus.phase_idx, {bus.bcd_tens, bus.bcd_ones}); end
        goto(664);
        checks++; if (bus.veh_lights !== 9'b100100001 || bus.phase_idx !== 2'd0) begin fails++; $display("FAIL flash_resume: veh %b idx %0d want 100100001 0", bus.veh_lights, bus.phase_idx); end
    endtask

    task automatic test_reset_mid_walk;
        goto(666);
        pulse_req(3'b010);
        goto(720);
        checks++; if (bus.ped_lights !== 6'b100110) begin fails++; $display("FAIL walk_p1: got %b want 100110", bus.ped_lights); end
        goto(725);
        pulse_req(3'b001);
        checks++; if (bus.ped_pending !== 3'b001) begin fails++; $display("FAIL pend_before_rst: got %b want 001", bus.ped_pending); end
        goto(730);
        reset = 1'b1;
        #1;
        checks++; if (bus.veh_lights !== 9'b100100100 || bus.ped_lights !== 6'b101010) begin fails++; $display("FAIL async_rst_lights: veh %b ped %b want 100100100 101010", bus.veh_lights, bus.ped_lights); end
        checks++; if (bus.ped_pending !== 3'b000 || {bus.bcd_tens, bus.bcd_ones} !== 8'h03 || bus.phase_idx !== 2'd0) begin fails++; $display("FAIL async_rst_state: pend %b bcd %h idx %0d want 000 03 0", bus.ped_pending, {bus.bcd_tens, bus.bcd_ones}, bus.phase_idx); end
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        goto(24);
        checks++; if (bus.veh_lights !== 9'b100100001 || bus.ped_lights !== 6'b101010) begin fails++; $display("FAIL rst_restart: veh %b ped %b want 100100001 101010", bus.veh_lights, bus.ped_lights); end
    endtask

    initial begin
        test_reset;
        test_normal_cycle;
        test_ped_walk;
        test_ped_during_walk;
        test_simultaneous;
        test_flash;
        test_reset_mid_walk;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
